// File: rtl/secuenciador_escritura_rtc_pkg.sv
// Shared definitions for the RTC write sequencer: register indices, RTC address map,
// command codes, group encodings and FSM state encoding.
package rtc_defs;

  localparam int N_REGS = 10;

  localparam logic [3:0] IDX_SEG        = 4'd0;
  localparam logic [3:0] IDX_MIN        = 4'd1;
  localparam logic [3:0] IDX_HORA       = 4'd2;
  localparam logic [3:0] IDX_DIA        = 4'd3;
  localparam logic [3:0] IDX_MES        = 4'd4;
  localparam logic [3:0] IDX_ANIO       = 4'd5;
  localparam logic [3:0] IDX_DIA_SEMANA = 4'd6;
  localparam logic [3:0] IDX_SEG_T      = 4'd7;
  localparam logic [3:0] IDX_MIN_T      = 4'd8;
  localparam logic [3:0] IDX_HORA_T     = 4'd9;

  localparam logic [7:0] CMD_ADDR = 8'hF0;
  localparam logic [7:0] CMD_CLK  = 8'hF1;
  localparam logic [7:0] CMD_TMR  = 8'hF2;

  typedef enum logic [1:0] {
    GRP_HORA  = 2'b00,
    GRP_FECHA = 2'b01,
    GRP_TIMER = 2'b10,
    GRP_ALL   = 2'b11
  } grupo_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_REQ     = 3'd2,
    ST_NEXT    = 3'd3,
    ST_CMD_REQ = 3'd4,
    ST_FIN     = 3'd5
  } estado_e;

  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      IDX_SEG:        a = 8'h21;
      IDX_MIN:        a = 8'h22;
      IDX_HORA:       a = 8'h23;
      IDX_DIA:        a = 8'h24;
      IDX_MES:        a = 8'h25;
      IDX_ANIO:       a = 8'h26;
      IDX_DIA_SEMANA: a = 8'h27;
      IDX_SEG_T:      a = 8'h41;
      IDX_MIN_T:      a = 8'h42;
      IDX_HORA_T:     a = 8'h43;
      default:        a = 8'h00;
    endcase
    return a;
  endfunction

  function automatic logic [3:0] first_idx(input grupo_e g);
    logic [3:0] i;
    case (g)
      GRP_HORA:  i = IDX_SEG;
      GRP_FECHA: i = IDX_DIA;
      GRP_TIMER: i = IDX_SEG_T;
      default:   i = IDX_SEG;
    endcase
    return i;
  endfunction

  function automatic logic [3:0] last_idx(input grupo_e g);
    logic [3:0] i;
    case (g)
      GRP_HORA:  i = IDX_HORA;
      GRP_FECHA: i = IDX_DIA_SEMANA;
      GRP_TIMER: i = IDX_HORA_T;
      default:   i = IDX_HORA_T;
    endcase
    return i;
  endfunction

  // Group "all" opens with the clock transfer; the timer transfer follows as a second command.
  function automatic logic [7:0] first_cmd(input grupo_e g);
    return (g == GRP_TIMER) ? CMD_TMR : CMD_CLK;
  endfunction

endpackage

// File: rtl/secuenciador_escritura_rtc_timeout.sv
// Handshake watchdog: counts request cycles while enabled and flags the cycle in which
// the wait reaches TIMEOUT_CYC cycles (counting the current one).
module rtc_wr_timeout #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int TO_W        = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = en && (cnt == LIMIT);

endmodule

// File: rtl/secuenciador_escritura_rtc.sv
// Walks a group of local time/date/timer registers and writes each one to the RTC bus
// controller over a req/done handshake, closing the group with transfer command writes.
module secuenciador_escritura_rtc
  import rtc_defs::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int TO_W        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] grupo,
  input  logic [7:0] dato_local,
  output logic [3:0] addr_mem_local,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] estado_dbg
);

  // Handshake: wr_addr/wr_data are stable for every cycle wr_req is high; a request
  // completes in the cycle wr_done is sampled high, and wr_req drops on the next cycle.

  estado_e    estado, estado_n;
  grupo_e     grp, grp_n;
  logic [3:0] idx, idx_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] data_q, data_n;
  logic       in_cmd, in_cmd_n;
  logic       cmd_sec, cmd_sec_n;
  logic       err_q, err_n;
  logic       to_hit;

  rtc_wr_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .TO_W       (TO_W)
  ) u_timeout (
    .clk(clk),
    .rst(reset),
    .clr(!wr_req),
    .en (wr_req),
    .hit(to_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= ST_IDLE;
      grp     <= GRP_HORA;
      idx     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      in_cmd  <= 1'b0;
      cmd_sec <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      estado  <= estado_n;
      grp     <= grp_n;
      idx     <= idx_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      in_cmd  <= in_cmd_n;
      cmd_sec <= cmd_sec_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    estado_n  = estado;
    grp_n     = grp;
    idx_n     = idx;
    addr_n    = addr_q;
    data_n    = data_q;
    in_cmd_n  = in_cmd;
    cmd_sec_n = cmd_sec;
    err_n     = 1'b0;
    case (estado)
      ST_IDLE: begin
        if (start) begin
          grp_n     = grupo_e'(grupo);
          idx_n     = first_idx(grupo_e'(grupo));
          in_cmd_n  = 1'b0;
          cmd_sec_n = 1'b0;
          estado_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        addr_n   = rtc_addr(idx);
        data_n   = dato_local;
        estado_n = ST_REQ;
      end
      ST_REQ, ST_CMD_REQ: begin
        // A completion arriving on the timeout cycle still wins.
        if (wr_done) begin
          estado_n = ST_NEXT;
        end else if (to_hit) begin
          estado_n = ST_IDLE;
          err_n    = 1'b1;
        end
      end
      ST_NEXT: begin
        if (!in_cmd) begin
          if (idx < last_idx(grp)) begin
            idx_n    = idx + 4'd1;
            estado_n = ST_LOAD;
          end else begin
            addr_n   = CMD_ADDR;
            data_n   = first_cmd(grp);
            in_cmd_n = 1'b1;
            estado_n = ST_CMD_REQ;
          end
        end else if ((grp == GRP_ALL) && !cmd_sec) begin
          data_n    = CMD_TMR;
          cmd_sec_n = 1'b1;
          estado_n  = ST_CMD_REQ;
        end else begin
          estado_n = ST_FIN;
        end
      end
      ST_FIN: begin
        estado_n = ST_IDLE;
      end
      default: begin
        estado_n = ST_IDLE;
      end
    endcase
  end

  assign wr_req         = (estado == ST_REQ) || (estado == ST_CMD_REQ);
  assign busy           = (estado != ST_IDLE) && (estado != ST_FIN);
  assign done           = (estado == ST_FIN);
  assign err            = err_q;
  assign addr_mem_local = idx;
  assign wr_addr        = addr_q;
  assign wr_data        = data_q;
  assign estado_dbg     = estado;

endmodule
